// File: rtl/rr_grant_sel.sv
// Four-requester round-robin grant sequencer driving a 2-to-4 decoder select/enable.
// Grants are held until done, request withdrawal or HOLD_MAX, with one dead cycle between grants.
module rr_grant_sel #(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] sel,
    output logic       sel_valid,
    output logic       timeout,
    output logic [1:0] dbg_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    logic [1:0] r_state;
    logic [1:0] r_ptr;
    logic [7:0] r_hold_cnt;
    logic [1:0] r_sel;
    logic       r_sel_valid;
    logic       r_timeout;

    logic [7:0] w_req2;
    logic [3:0] w_rot;
    logic [1:0] w_offset;
    logic [1:0] w_winner;
    logic       w_any;
    logic       w_hold_hit;
    logic       w_owner_req;
    logic       w_release;
    logic       w_to_only;

    // Rotate the request vector so bit 0 is the requester at ptr; the lowest set bit wins.
    assign w_req2 = {req, req};
    assign w_rot  = w_req2[r_ptr +: 4];

    always_comb begin
        w_offset = 2'd3;
        if (w_rot[0])      w_offset = 2'd0;
        else if (w_rot[1]) w_offset = 2'd1;
        else if (w_rot[2]) w_offset = 2'd2;
    end

    assign w_winner    = r_ptr + w_offset;
    assign w_any       = |req;
    assign w_hold_hit  = (r_hold_cnt == HOLD_LIM);
    assign w_owner_req = req[r_sel];
    assign w_release   = done | ~w_owner_req | w_hold_hit;
    // Timeout is flagged only when the counter alone forced the release.
    assign w_to_only   = ~done & w_owner_req & w_hold_hit;

    // Handshake: req[i] is a level held by requester i; done is a one-cycle release
    // from the current owner and is only meaningful while sel_valid is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 2'd0;
            r_hold_cnt  <= 8'd0;
            r_sel       <= 2'd0;
            r_sel_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE, ST_GAP: begin
                    if (w_any) begin
                        r_state     <= ST_GRANT;
                        r_sel       <= w_winner;
                        r_sel_valid <= 1'b1;
                        r_hold_cnt  <= 8'd1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_state     <= ST_GAP;
                        r_sel_valid <= 1'b0;
                        r_ptr       <= r_sel + 2'd1;
                        r_hold_cnt  <= 8'd0;
                        r_timeout   <= w_to_only;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_sel_valid <= 1'b0;
                end
            endcase
        end
    end

    assign sel       = r_sel;
    assign sel_valid = r_sel_valid;
    assign timeout   = r_timeout;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_rr_grant_sel.sv
// Directed bench for rr_grant_sel with HOLD_MAX = 4; inputs change and outputs are
// checked on the falling edge, so each tick observes the result of one rising edge.
module tb_rr_grant_sel;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [1:0] sel;
    logic       sel_valid;
    logic       timeout;
    logic [1:0] dbg_state;

    int total;
    int bad;

    rr_grant_sel #(.HOLD_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .sel       (sel),
        .sel_valid (sel_valid),
        .timeout   (timeout),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [1:0] e_sel, input logic e_v, input logic e_to);
        total++;
        assert (sel === e_sel) else begin
            bad++;
            $error("FAIL %s sel: got %0d want %0d", tag, sel, e_sel);
        end
        total++;
        assert (sel_valid === e_v) else begin
            bad++;
            $error("FAIL %s sel_valid: got %0b want %0b", tag, sel_valid, e_v);
        end
        total++;
        assert (timeout === e_to) else begin
            bad++;
            $error("FAIL %s timeout: got %0b want %0b", tag, timeout, e_to);
        end
    endtask

    task automatic chk_st(input string tag, input logic [1:0] e_st);
        total++;
        assert (dbg_state === e_st) else begin
            bad++;
            $error("FAIL %s state: got %0d want %0d", tag, dbg_state, e_st);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    logic [1:0] seq_a[4];

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b1;
        req   = 4'b1111;
        done  = 1'b0;

        // Reset and idle
        #1 rst_n = 1'b0;
        #1 chk("reset_async", 2'd0, 1'b0, 1'b0);
        chk_st("reset_async", ST_IDLE);
        tick();
        tick();
        chk("reset_held", 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        req   = 4'b0000;
        done  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("idle_%0d", i), 2'd0, 1'b0, 1'b0);
        end
        chk_st("idle_end", ST_IDLE);
        done = 1'b0;

        // Single requester, done on third grant cycle
        req = 4'b0100;
        tick();
        chk("single_g1", 2'd2, 1'b1, 1'b0);
        chk_st("single_g1", ST_GRANT);
        req = 4'b0101;
        tick();
        chk("single_g2", 2'd2, 1'b1, 1'b0);
        req = 4'b0100;
        tick();
        chk("single_g3", 2'd2, 1'b1, 1'b0);
        done = 1'b1;
        req  = 4'b0000;
        tick();
        chk("single_gap", 2'd2, 1'b0, 1'b0);
        chk_st("single_gap", ST_GAP);
        done = 1'b0;
        tick();
        chk("single_idle", 2'd2, 1'b0, 1'b0);
        chk_st("single_idle", ST_IDLE);
        // ptr is now 3: req 0011 must wrap to requester 0
        req = 4'b0011;
        tick();
        chk("wrap_grant", 2'd0, 1'b1, 1'b0);

        // Round-robin rotation, done held high (ignored outside GRANT)
        do_reset();
        req  = 4'b1111;
        done = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rot_g%0d", k), 2'(k % 4), 1'b1, 1'b0);
            tick();
            chk($sformatf("rot_gap%0d", k), 2'(k % 4), 1'b0, 1'b0);
            tick();
        end

        // Two requesters 0 and 3 alternate
        do_reset();
        seq_a[0] = 2'd0;
        seq_a[1] = 2'd3;
        seq_a[2] = 2'd0;
        seq_a[3] = 2'd3;
        req  = 4'b1001;
        done = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("alt_g%0d", k), seq_a[k], 1'b1, 1'b0);
            tick();
            chk($sformatf("alt_gap%0d", k), seq_a[k], 1'b0, 1'b0);
            tick();
        end

        // Timeout after 4 grant cycles, then re-grant
        do_reset();
        req = 4'b0010;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk($sformatf("to_g%0d", c), 2'd1, 1'b1, 1'b0);
        end
        tick();
        chk("to_pulse", 2'd1, 1'b0, 1'b1);
        chk_st("to_pulse", ST_GAP);
        tick();
        chk("to_regrant", 2'd1, 1'b1, 1'b0);
        // Second grant: done coincides with the hold limit, so no timeout pulse
        tick();
        tick();
        tick();
        chk("to_done_g4", 2'd1, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        chk("to_done_gap", 2'd1, 1'b0, 1'b0);
        done = 1'b0;
        tick();
        chk("to_done_regrant", 2'd1, 1'b1, 1'b0);

        // Withdrawal releases without timeout; pending requester 0 follows
        do_reset();
        req = 4'b0100;
        tick();
        chk("wd_grant", 2'd2, 1'b1, 1'b0);
        req = 4'b0001;
        tick();
        chk("wd_gap", 2'd2, 1'b0, 1'b0);
        tick();
        chk("wd_next", 2'd0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a grant to requester 3
        do_reset();
        req = 4'b1000;
        tick();
        chk("ar_grant", 2'd3, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk("ar_async", 2'd0, 1'b0, 1'b0);
        chk_st("ar_async", ST_IDLE);
        req = 4'b1010;
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_after", 2'd1, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
